// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception inputs and pipeline-control outputs.
// The slave modport is the controller side; the master modport is the pipeline side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic             perf_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_timeout;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i, perf_clr,
        input  stall, flush, new_pc, stall_cnt, stall_timeout
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i, perf_clr,
        output stall, flush, new_pc, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for a 6-stage MIPS pipeline: stall merge, exception
// freeze-then-flush sequencing, stall performance counter and watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 32,
    parameter int          MAX_STALL  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam logic [31:0]      ERET_CODE = 32'h0000_000e;
    localparam int               RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // The exception-detect (EXC) cycle is RUN with a nonzero code; it is
    // never held in a register, so only RUN and FLUSH are encoded.
    typedef enum logic {S_RUN, S_FLUSH} state_e;

    state_e           state_q, state_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             to_q, to_d;
    logic [5:0]       stall_c;

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        stall_c  = 6'b000000;
        unique case (state_q)
            S_RUN: begin
                if (bus.excepttype_i != 32'd0) begin
                    stall_c  = 6'b011111;
                    new_pc_d = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
                    flush_d  = 1'b1;
                    state_d  = S_FLUSH;
                end else if (bus.stallreq_from_mem) begin
                    stall_c = 6'b011111;
                end else if (bus.stallreq_from_ex) begin
                    stall_c = 6'b001111;
                end else if (bus.stallreq_from_id) begin
                    stall_c = 6'b000111;
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        if (rst) stall_c = 6'b000000;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.perf_clr)                        cnt_d = '0;
        else if (stall_c[2] && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

        run_d = '0;
        if (stall_c[2]) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        to_d = to_q | (run_d == RUN_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
            cnt_q    <= '0;
            run_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            to_q     <= to_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_cnt     = cnt_q;
    assign bus.stall_timeout = to_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model pushes expected registered
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_pipe_ctrl;
    localparam int          CNT_W     = 4;
    localparam int          MAX_STALL = 8;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic             fl;
        logic [31:0]      pc;
        logic [CNT_W-1:0] cnt;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference model state
    logic             m_flush_st;
    logic [31:0]      m_pc;
    logic [CNT_W-1:0] m_cnt;
    int               m_run;
    logic             m_to;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_st = 1'b0;
        m_pc       = 32'd0;
        m_cnt      = '0;
        m_run      = 0;
        m_to       = 1'b0;
    endtask

    // Called at a falling edge: drive, check combinational stall, push the
    // expected registered state, then compare it after the rising edge.
    task automatic cycle(input logic id, input logic ex, input logic mem,
                         input logic [31:0] code, input logic [31:0] epc, input logic clr);
        logic [5:0] es;
        exp_t       e, got;
        bus.stallreq_from_id  = id;
        bus.stallreq_from_ex  = ex;
        bus.stallreq_from_mem = mem;
        bus.excepttype_i      = code;
        bus.cp0_epc_i         = epc;
        bus.perf_clr          = clr;
        #1;
        es = 6'b000000;
        e.fl = 1'b0;
        if (m_flush_st) begin
            m_flush_st = 1'b0;
        end else if (code != 32'd0) begin
            es = 6'b011111;
            m_pc = (code == 32'h0000_000e) ? epc : EXC_VEC;
            e.fl = 1'b1;
            m_flush_st = 1'b1;
        end else if (mem) es = 6'b011111;
        else if (ex)      es = 6'b001111;
        else if (id)      es = 6'b000111;
        chk("stall", {26'd0, bus.stall}, {26'd0, es});

        if (clr) m_cnt = '0;
        else if (es[2] && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (es[2]) m_run = (m_run >= MAX_STALL) ? MAX_STALL : m_run + 1;
        else       m_run = 0;
        if (m_run == MAX_STALL) m_to = 1'b1;
        e.pc  = m_pc;
        e.cnt = m_cnt;
        e.to  = m_to;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("flush",         {31'd0, bus.flush},         {31'd0, got.fl});
        chk("new_pc",        bus.new_pc,                 got.pc);
        chk("stall_cnt",     32'(bus.stall_cnt),         32'(got.cnt));
        chk("stall_timeout", {31'd0, bus.stall_timeout}, {31'd0, got.to});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        bus.stallreq_from_id  = 1'b1;
        bus.stallreq_from_ex  = 1'b0;
        bus.stallreq_from_mem = 1'b1;
        bus.excepttype_i      = 32'h0000_0008;
        bus.cp0_epc_i         = 32'h0000_1234;
        bus.perf_clr          = 1'b0;
        #3;
        chk("rst_stall",   {26'd0, bus.stall}, 32'd0);
        chk("rst_flush",   {31'd0, bus.flush}, 32'd0);
        chk("rst_new_pc",  bus.new_pc, 32'd0);
        chk("rst_cnt",     32'(bus.stall_cnt), 32'd0);
        chk("rst_timeout", {31'd0, bus.stall_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // priority
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // exception, then ERET while EX requests a stall throughout
        cycle(1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_1234, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_1234, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_000e, 32'h0000_1234, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_000e, 32'h0000_5678, 1'b0);
        chk("eret_pc", bus.new_pc, 32'h0000_1234);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(1);

        // watchdog: 7 / gap / 7 stays quiet, 8 in a row fires and sticks
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        idle(1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        chk("wd_quiet", {31'd0, bus.stall_timeout}, 32'd0);
        idle(1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        chk("wd_fire", {31'd0, bus.stall_timeout}, 32'd1);
        idle(3);
        chk("wd_sticky", {31'd0, bus.stall_timeout}, 32'd1);
        rst = 1'b1;
        #1;
        chk("wd_rst", {31'd0, bus.stall_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // counter saturation and clear-wins-over-increment
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("cnt_sat", 32'(bus.stall_cnt), 32'd15);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("cnt_clr", 32'(bus.stall_cnt), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("cnt_two", 32'(bus.stall_cnt), 32'd2);
        // freeze cycle of an exception counts as a stall cycle
        cycle(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'd0, 1'b0);

        // async reset in the middle of FLUSH
        bus.stallreq_from_id  = 1'b0;
        bus.stallreq_from_ex  = 1'b0;
        bus.stallreq_from_mem = 1'b0;
        bus.excepttype_i      = 32'd0;
        #2;
        chk("flush_before_rst", {31'd0, bus.flush}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_flush", {31'd0, bus.flush}, 32'd0);
        chk("async_cnt",   32'(bus.stall_cnt), 32'd0);
        chk("async_pc",    bus.new_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(2);

        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
